// File: rtl/mini_src_pkg.sv
// ---------------------------------------------------------------------------
// mini_src_pkg
// Shared types and constants for the mini_src register file.
//   rf_state_t        : init sequencer states (idle / walking / done pulse)
//   RF_DEFAULT_WIDTH  : default register width
//   RF_DEFAULT_DEPTH  : default register count
//   RESET_VALUE       : default value loaded on clear and by the init walk
// ---------------------------------------------------------------------------
package mini_src_pkg;

    typedef enum logic [1:0] {
        RF_IDLE = 2'd0,
        RF_INIT = 2'd1,
        RF_DONE = 2'd2
    } rf_state_t;

    localparam int          RF_DEFAULT_WIDTH = 32;
    localparam int          RF_DEFAULT_DEPTH = 16;
    localparam logic [31:0] RESET_VALUE      = 32'h0000_0000;

endpackage

// File: rtl/gp_register_file_init_seq.sv
// ---------------------------------------------------------------------------
// rf_init_seq
// Initialisation sequencer: on request walks a counter across every register
// index, one per cycle, then emits a single done pulse.
//   clock       in  : system clock, rising edge
//   clear       in  : asynchronous active-high reset
//   init_req    in  : start request, only honoured in RF_IDLE
//   init_busy   out : registered, high while the walk runs (DEPTH cycles)
//   init_done   out : registered, one-cycle pulse after the last index
//   init_wr_en  out : storage write strobe for the walk
//   init_wr_idx out : register index being initialised this cycle
// ---------------------------------------------------------------------------
module rf_init_seq
    import mini_src_pkg::*;
#(
    parameter int DEPTH = RF_DEFAULT_DEPTH,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             init_req,
    output logic             init_busy,
    output logic             init_done,
    output logic             init_wr_en,
    output logic [SEL_W-1:0] init_wr_idx
);

    // One extra counter bit so that DEPTH = 2**SEL_W never wraps mid-walk.
    localparam logic [SEL_W:0] LAST_IDX = (SEL_W + 1)'(DEPTH - 1);
    localparam logic [SEL_W:0] CNT_ONE  = (SEL_W + 1)'(1);

    rf_state_t      state_r;
    rf_state_t      state_next_s;
    logic [SEL_W:0] count_r;
    logic [SEL_W:0] count_next_s;
    logic           busy_r;
    logic           done_r;

    // Next-state and walk-counter logic.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            RF_IDLE: begin
                if (init_req) begin
                    state_next_s = RF_INIT;
                    count_next_s = '0;
                end else begin
                    state_next_s = RF_IDLE;
                    count_next_s = count_r;
                end
            end
            RF_INIT: begin
                count_next_s = count_r + CNT_ONE;
                if (count_r == LAST_IDX) begin
                    state_next_s = RF_DONE;
                end else begin
                    state_next_s = RF_INIT;
                end
            end
            RF_DONE: begin
                state_next_s = RF_IDLE;
            end
            default: begin
                state_next_s = RF_IDLE;
                count_next_s = '0;
            end
        endcase
    end

    // State, counter and registered status flags (flags follow next state).
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= RF_IDLE;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            busy_r  <= (state_next_s == RF_INIT);
            done_r  <= (state_next_s == RF_DONE);
        end
    end

    assign init_busy   = busy_r;
    assign init_done   = done_r;
    assign init_wr_en  = (state_r == RF_INIT);
    assign init_wr_idx = count_r[SEL_W-1:0];

endmodule

// File: rtl/gp_register_file.sv
// ---------------------------------------------------------------------------
// gp_register_file
// General-purpose register file: one write port, two registered read ports,
// optional hardwired-zero R0, optional write-to-read bypass and a built-in
// sequencer that walks every register back to INIT_VALUE.
//   clock      in  : system clock, rising edge
//   clear      in  : asynchronous active-high reset
//   wr_en      in  : write strobe
//   wr_sel     in  : write index
//   wr_data    in  : write data
//   wr_reject  out : one-cycle pulse when a requested write was dropped
//   rd_sel_a/b in  : read indices
//   rd_data_a/b out: registered read data (1-cycle latency)
//   init_req   in  : start the init walk (sampled in idle)
//   init_busy  out : high while the walk runs
//   init_done  out : one-cycle pulse at the end of the walk
// ---------------------------------------------------------------------------
module gp_register_file
    import mini_src_pkg::*;
#(
    parameter int          WIDTH      = RF_DEFAULT_WIDTH,
    parameter int          DEPTH      = RF_DEFAULT_DEPTH,
    parameter int          SEL_W      = $clog2(DEPTH),
    parameter logic [31:0] INIT_VALUE = RESET_VALUE,
    parameter bit          R0_ZERO    = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_reject,
    input  logic [SEL_W-1:0] rd_sel_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [SEL_W-1:0] rd_sel_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             init_req,
    output logic             init_busy,
    output logic             init_done
);

    localparam logic [WIDTH-1:0] INIT_W  = WIDTH'(INIT_VALUE);
    localparam logic [SEL_W:0]   DEPTH_W = (SEL_W + 1)'(DEPTH);

    logic             init_busy_s;
    logic             init_done_s;
    logic             init_wr_en_s;
    logic [SEL_W-1:0] init_wr_idx_s;

    logic             wr_in_range_s;
    logic             wr_is_r0_s;
    logic             seq_idle_s;
    logic             wr_accept_s;

    logic [WIDTH-1:0] regs_s    [DEPTH];
    logic [SEL_W-1:0] rd_sel_s  [2];
    logic [WIDTH-1:0] rd_next_s [2];

    logic [WIDTH-1:0] rd_data_a_r;
    logic [WIDTH-1:0] rd_data_b_r;
    logic             wr_reject_r;

    rf_init_seq #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_init_seq (
        .clock       (clock),
        .clear       (clear),
        .init_req    (init_req),
        .init_busy   (init_busy_s),
        .init_done   (init_done_s),
        .init_wr_en  (init_wr_en_s),
        .init_wr_idx (init_wr_idx_s)
    );

    // Write qualification: the sequencer owns the array outside idle, and
    // out-of-range or hardwired-zero targets are dropped.
    always_comb begin
        wr_in_range_s = ({1'b0, wr_sel} < DEPTH_W);
        wr_is_r0_s    = R0_ZERO && (wr_sel == '0);
        seq_idle_s    = !(init_busy_s || init_done_s);
        wr_accept_s   = wr_en && seq_idle_s && wr_in_range_s && !wr_is_r0_s;
    end

    // Storage: one register per index, each with its own reset/init value.
    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        localparam logic [WIDTH-1:0] SLOT_INIT = (R0_ZERO && (g == 0)) ? '0 : INIT_W;
        localparam logic [SEL_W-1:0] SLOT_IDX  = SEL_W'(g);

        logic [WIDTH-1:0] word_r;

        // Register g: init walk has priority over (already blocked) user writes.
        always_ff @(posedge clock or posedge clear) begin
            if (clear) begin
                word_r <= SLOT_INIT;
            end else if (init_wr_en_s && (init_wr_idx_s == SLOT_IDX)) begin
                word_r <= SLOT_INIT;
            end else if (wr_accept_s && (wr_sel == SLOT_IDX)) begin
                word_r <= wr_data;
            end else begin
                word_r <= word_r;
            end
        end

        assign regs_s[g] = word_r;
    end

    assign rd_sel_s[0] = rd_sel_a;
    assign rd_sel_s[1] = rd_sel_b;

    // Read muxing for both ports, with optional forwarding of an accepted write.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_next_s[p] = '0;
            if (({1'b0, rd_sel_s[p]} < DEPTH_W) && !(R0_ZERO && (rd_sel_s[p] == '0))) begin
                rd_next_s[p] = regs_s[rd_sel_s[p]];
            end else begin
                rd_next_s[p] = '0;
            end
            if (BYPASS && wr_accept_s && (wr_sel == rd_sel_s[p])) begin
                rd_next_s[p] = wr_data;
            end else begin
                rd_next_s[p] = rd_next_s[p];
            end
        end
    end

    // Registered read data and write-reject pulse.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            rd_data_a_r <= '0;
            rd_data_b_r <= '0;
            wr_reject_r <= 1'b0;
        end else begin
            rd_data_a_r <= rd_next_s[0];
            rd_data_b_r <= rd_next_s[1];
            wr_reject_r <= wr_en && !wr_accept_s;
        end
    end

    assign rd_data_a = rd_data_a_r;
    assign rd_data_b = rd_data_b_r;
    assign wr_reject = wr_reject_r;
    assign init_busy = init_busy_s;
    assign init_done = init_done_s;

endmodule
